// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state encoding
// and the counter-width helper used to size the chunk index.
package seq_chunk_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One spare bit so the chunk index never wraps inside an operation.
    function automatic int cnt_width(input int nch);
        return $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/chunk_ha_adder.sv
// Combinational CHUNK-bit ripple adder; every full-adder cell is two
// half-adders plus an OR so the carry path stays a plain AND/OR chain.
module chunk_ha_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             carry_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_fa
            logic ha1_sum;
            logic ha1_carry;
            logic ha2_carry;

            assign ha1_sum      = a[gi] ^ b[gi];
            assign ha1_carry    = a[gi] & b[gi];
            assign sum[gi]      = ha1_sum ^ carry[gi];
            assign ha2_carry    = ha1_sum & carry[gi];
            assign carry[gi+1]  = ha1_carry | ha2_carry;
        end
    endgenerate

    assign cout      = carry[CHUNK];
    // Carry into the top bit; XOR with cout gives signed overflow on the last chunk.
    assign carry_msb = carry[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit slice per clock with the
// carry held in a register, start/done handshake toward the datapath.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH   = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int CNT_W = cnt_width(NCH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("seq_chunk_adder: CHUNK must be at least 1");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_carry_msb;
    logic [WIDTH-1:0] acc_shift;

    chunk_ha_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a         (a_reg[CHUNK-1:0]),
        .b         (b_reg[CHUNK-1:0]),
        .cin       (carry_reg),
        .sum       (chunk_sum),
        .cout      (chunk_cout),
        .carry_msb (chunk_carry_msb)
    );

    // Chunks enter at the top and drift down, so after NCH steps the
    // first (least significant) chunk sits at bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_acc_full
            assign acc_shift = chunk_sum;
        end else begin : g_acc_shift
            assign acc_shift = {chunk_sum, acc_reg[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1; cin is deliberately ignored.
                    a_next     = a;
                    b_next     = b ^ {WIDTH{sub}};
                    carry_next = sub ? 1'b1 : cin;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next   = acc_shift;
                a_next     = a_reg >> CHUNK;
                b_next     = b_reg >> CHUNK;
                carry_next = chunk_cout;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    sum_next   = acc_shift;
                    cout_next  = chunk_cout;
                    ovf_next   = chunk_cout ^ chunk_carry_msb;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomized and directed bench for seq_chunk_adder at WIDTH=16 with
// CHUNK=4, CHUNK=1 and CHUNK=16 instances, checked against integer arithmetic.
module tb_seq_chunk_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         start_s [3];
    logic         busy_o  [3];
    logic         done_o  [3];
    logic [W-1:0] sum_o   [3];
    logic         cout_o  [3];
    logic         ovf_o   [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Index 0: CHUNK=4 (NCH 4), 1: CHUNK=1 (NCH 16), 2: CHUNK=16 (NCH 1)
    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]));
    seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]));
    seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_o[2]), .done(done_o[2]), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]));

    function automatic int nch(input int which);
        case (which)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         input logic mcin, output logic [W-1:0] es, output logic ec,
                         output logic eo);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            ur = ua - ub;
            ec = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + longint'(mcin);
            ec = (ur >= 65536);
            sr = sa + sb + longint'(mcin);
        end
        es = W'(ur);
        eo = (sr > 32767) || (sr < -32768);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; returns the same way after the accepting edge.
    task automatic issue(input int which, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tsub, input logic tcin);
        a = ta;
        b = tb_v;
        sub = tsub;
        cin = tcin;
        start_s[which] = 1'b1;
        @(posedge clk);
        #1;
        start_s[which] = 1'b0;
    endtask

    task automatic wait_done(input int which, input int already, output int lat);
        lat = already;
        while (lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_o[which]) break;
        end
    endtask

    task automatic run_op(input int which, input string tag, input logic [W-1:0] ta,
                          input logic [W-1:0] tb_v, input logic tsub, input logic tcin);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat;
        model(ta, tb_v, tsub, tcin, es, ec, eo);
        issue(which, ta, tb_v, tsub, tcin);
        check({tag, ".busy"}, 64'(busy_o[which]), 64'd1);
        wait_done(which, 0, lat);
        check({tag, ".lat"}, 64'(lat), 64'(nch(which)));
        check({tag, ".sum"}, 64'(sum_o[which]), 64'(es));
        check({tag, ".cout"}, 64'(cout_o[which]), 64'(ec));
        check({tag, ".ovf"}, 64'(ovf_o[which]), 64'(eo));
        $display("txn %s inst=%0d a=%04h b=%04h sub=%0d cin=%0d sum=%04h cout=%0d ovf=%0d lat=%0d",
                 tag, which, ta, tb_v, tsub, tcin, sum_o[which], cout_o[which], ovf_o[which], lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dones;
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;

        #2 rst_n = 1'b0;
        step(2);
        for (int i = 0; i < 3; i++) begin
            check("reset.busy", 64'(busy_o[i]), 64'd0);
            check("reset.done", 64'(done_o[i]), 64'd0);
            check("reset.sum", 64'(sum_o[i]), 64'd0);
            check("reset.cout_ovf", 64'({cout_o[i], ovf_o[i]}), 64'd0);
        end
        rst_n = 1'b1;
        step(1);

        run_op(0, "wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("wrap.const", 64'({cout_o[0], ovf_o[0], sum_o[0]}), 64'({1'b1, 1'b0, 16'h0000}));
        step(1);
        check("wrap.pulse", 64'(done_o[0]), 64'd0);
        check("wrap.hold", 64'(sum_o[0]), 64'h0000);

        run_op(0, "subovf", 16'h8000, 16'h0001, 1'b1, 1'b0);
        check("subovf.const", 64'({cout_o[0], ovf_o[0], sum_o[0]}), 64'({1'b1, 1'b1, 16'h7FFF}));
        step(1);
        run_op(0, "addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1 & 1'b0);
        check("addovf.const", 64'({cout_o[0], ovf_o[0], sum_o[0]}), 64'({1'b0, 1'b1, 16'h8000}));
        step(2);

        // Start pulsed two cycles into an op must be ignored.
        issue(0, 16'h1234, 16'h4321, 1'b0, 1'b1);
        step(2);
        a = 16'hAAAA;
        b = 16'hFFFF;
        start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        wait_done(0, 3, lat);
        check("ignore.lat", 64'(lat), 64'd4);
        check("ignore.sum", 64'(sum_o[0]), 64'h5556);
        $display("txn ignore inst=0 sum=%04h lat=%0d", sum_o[0], lat);
        // Back-to-back start in the done cycle.
        run_op(0, "b2b", 16'h0F0F, 16'h0101, 1'b0, 1'b0);
        step(1);
        check("b2b.no_extra_done", 64'(done_o[0]), 64'd0);

        // Reset mid-operation abandons it with no later done.
        issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        step(2);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 64'(busy_o[0]), 64'd0);
        check("midrst.done", 64'(done_o[0]), 64'd0);
        check("midrst.sum", 64'(sum_o[0]), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (done_o[0]) dones++;
        end
        check("midrst.no_done", 64'(dones), 64'd0);
        $display("txn midrst inst=0 dones_after_release=%0d", dones);

        run_op(2, "c16", 16'h00FF, 16'h0F01, 1'b0, 1'b0);
        check("c16.const", 64'(sum_o[2]), 64'h1000);
        step(1);
        run_op(1, "c1", 16'h00FF, 16'h0F01, 1'b0, 1'b0);
        check("c1.const", 64'(sum_o[1]), 64'h1000);
        step(1);

        for (int n = 0; n < 1000; n++) begin
            run_op(0, "rnd4", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            step($urandom_range(0, 2));
        end
        for (int n = 0; n < 40; n++) begin
            run_op(1, "rnd1", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            run_op(2, "rnd16", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
